// File: rtl/axis_srl_pkg.sv
// rtl/axis_srl_pkg.sv - packed-word layout and count-width helpers for the SRL frame FIFO.
// AXIS_SRL_FRAME_FIFO_OUT_REG_EN adds the output skid word to the count range.
package axis_srl_pkg;

  localparam int FIELD_DATA = 0;
  localparam int FIELD_KEEP = 1;
  localparam int FIELD_LAST = 2;
  localparam int FIELD_ID   = 3;
  localparam int FIELD_DEST = 4;
  localparam int FIELD_USER = 5;
  localparam int FIELD_NUM  = 6;

`ifdef AXIS_SRL_FRAME_FIFO_OUT_REG_EN
  localparam int OUT_REG_WORDS = 1;
`else
  localparam int OUT_REG_WORDS = 0;
`endif

  function automatic int field_width(int field, int data_w, int keep_en, int keep_w,
                                     int last_en, int id_en, int id_w, int dest_en,
                                     int dest_w, int user_en, int user_w);
    case (field)
      FIELD_DATA: return data_w;
      FIELD_KEEP: return (keep_en != 0) ? keep_w : 0;
      FIELD_LAST: return (last_en != 0) ? 1 : 0;
      FIELD_ID:   return (id_en != 0) ? id_w : 0;
      FIELD_DEST: return (dest_en != 0) ? dest_w : 0;
      FIELD_USER: return (user_en != 0) ? user_w : 0;
      default:    return 0;
    endcase
  endfunction

  // Offset of a field is the sum of the enabled fields packed below it;
  // offset of FIELD_NUM is therefore the total packed width.
  function automatic int field_offset(int field, int data_w, int keep_en, int keep_w,
                                      int last_en, int id_en, int id_w, int dest_en,
                                      int dest_w, int user_en, int user_w);
    int off;
    off = 0;
    for (int f = 0; f < field; f++) begin
      off += field_width(f, data_w, keep_en, keep_w, last_en, id_en, id_w,
                         dest_en, dest_w, user_en, user_w);
    end
    return off;
  endfunction

  function automatic int count_width(int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axis_srl_shreg.sv
// rtl/axis_srl_shreg.sv - DEPTH x WIDTH shift register, new word at entry 0, indexed read.
module axis_srl_shreg #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = (int'(rd_idx) < DEPTH) ? mem[rd_idx] : '0;

endmodule

// File: rtl/axis_srl_frame_fifo.sv
// rtl/axis_srl_frame_fifo.sv - SRL AXI-Stream FIFO with optional store-and-forward frame gating.
// AXIS_SRL_FRAME_FIFO_OUT_REG_EN adds a registered one-word output stage.
module axis_srl_frame_fifo
  import axis_srl_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int LAST_ENABLE = 1,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int FRAME_FIFO  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [count_width(DEPTH + OUT_REG_WORDS)-1:0] count,
  output logic [count_width(DEPTH + OUT_REG_WORDS)-1:0] frame_count
);

  localparam int CW = count_width(DEPTH + OUT_REG_WORDS);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int KEEP_OFF = field_offset(FIELD_KEEP, DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH,
      LAST_ENABLE, ID_ENABLE, ID_WIDTH, DEST_ENABLE, DEST_WIDTH, USER_ENABLE, USER_WIDTH);
  localparam int LAST_OFF = field_offset(FIELD_LAST, DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH,
      LAST_ENABLE, ID_ENABLE, ID_WIDTH, DEST_ENABLE, DEST_WIDTH, USER_ENABLE, USER_WIDTH);
  localparam int ID_OFF = field_offset(FIELD_ID, DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH,
      LAST_ENABLE, ID_ENABLE, ID_WIDTH, DEST_ENABLE, DEST_WIDTH, USER_ENABLE, USER_WIDTH);
  localparam int DEST_OFF = field_offset(FIELD_DEST, DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH,
      LAST_ENABLE, ID_ENABLE, ID_WIDTH, DEST_ENABLE, DEST_WIDTH, USER_ENABLE, USER_WIDTH);
  localparam int USER_OFF = field_offset(FIELD_USER, DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH,
      LAST_ENABLE, ID_ENABLE, ID_WIDTH, DEST_ENABLE, DEST_WIDTH, USER_ENABLE, USER_WIDTH);
  localparam int W = field_offset(FIELD_NUM, DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH,
      LAST_ENABLE, ID_ENABLE, ID_WIDTH, DEST_ENABLE, DEST_WIDTH, USER_ENABLE, USER_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  s_word;
  logic [W-1:0]  srl_word;
  logic [W-1:0]  m_word;
  logic [CW-1:0] srl_count;
  logic [CW-1:0] srl_count_next;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] srl_frames;
  logic [AW-1:0] rd_idx;
  logic          s_ready;
  logic          pass;
  logic          in_xfer;
  logic          out_xfer;
  logic          in_last;
  logic          srl_last;
  logic          srl_valid;
  logic          srl_pop;

  assign s_word[0 +: DATA_WIDTH] = s_axis_tdata;
  assign m_axis_tdata            = m_word[0 +: DATA_WIDTH];

  // Disabled sideband is never stored; its outputs take their neutral value.
  if (KEEP_ENABLE != 0) begin : g_keep
    assign s_word[KEEP_OFF +: KEEP_WIDTH] = s_axis_tkeep;
    assign m_axis_tkeep = m_word[KEEP_OFF +: KEEP_WIDTH];
  end else begin : g_no_keep
    logic unused_keep;
    assign unused_keep  = ^s_axis_tkeep;
    assign m_axis_tkeep = '1;
  end

  if (LAST_ENABLE != 0) begin : g_last
    assign s_word[LAST_OFF] = s_axis_tlast;
    assign in_last          = s_axis_tlast;
    assign srl_last         = srl_word[LAST_OFF];
    assign m_axis_tlast     = m_word[LAST_OFF];
  end else begin : g_no_last
    logic unused_last;
    assign unused_last  = s_axis_tlast;
    assign in_last      = 1'b1;
    assign srl_last     = 1'b1;
    assign m_axis_tlast = 1'b1;
  end

  if (ID_ENABLE != 0) begin : g_id
    assign s_word[ID_OFF +: ID_WIDTH] = s_axis_tid;
    assign m_axis_tid = m_word[ID_OFF +: ID_WIDTH];
  end else begin : g_no_id
    logic unused_id;
    assign unused_id  = ^s_axis_tid;
    assign m_axis_tid = '0;
  end

  if (DEST_ENABLE != 0) begin : g_dest
    assign s_word[DEST_OFF +: DEST_WIDTH] = s_axis_tdest;
    assign m_axis_tdest = m_word[DEST_OFF +: DEST_WIDTH];
  end else begin : g_no_dest
    logic unused_dest;
    assign unused_dest  = ^s_axis_tdest;
    assign m_axis_tdest = '0;
  end

  if (USER_ENABLE != 0) begin : g_user
    assign s_word[USER_OFF +: USER_WIDTH] = s_axis_tuser;
    assign m_axis_tuser = m_word[USER_OFF +: USER_WIDTH];
  end else begin : g_no_user
    logic unused_user;
    assign unused_user  = ^s_axis_tuser;
    assign m_axis_tuser = '0;
  end

  assign rd_idx = AW'(srl_count - 1'b1);

  axis_srl_shreg #(
    .DEPTH (DEPTH),
    .WIDTH (W),
    .AW    (AW)
  ) u_shreg (
    .clk      (clk),
    .shift_en (in_xfer),
    .din      (s_word),
    .rd_idx   (rd_idx),
    .dout     (srl_word)
  );

  assign s_axis_tready = s_ready;
  assign in_xfer       = s_axis_tvalid && s_ready;
  assign out_xfer      = m_axis_tvalid && m_axis_tready;
  assign srl_valid     = (srl_count != '0) &&
                         ((FRAME_FIFO == 0) || (srl_frames != '0) || pass);

`ifdef AXIS_SRL_FRAME_FIFO_OUT_REG_EN
  logic         out_valid;
  logic [W-1:0] out_word;

  // A tlast word already in the skid register is not a frame the SRL can release.
  assign srl_frames    = frame_cnt - CW'(out_valid && m_axis_tlast);
  assign srl_pop       = srl_valid && (!out_valid || m_axis_tready);
  assign m_axis_tvalid = out_valid;
  assign m_word        = out_word;
  assign count         = srl_count + CW'(out_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (srl_pop) begin
      out_valid <= 1'b1;
    end else if (m_axis_tready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srl_pop) begin
      out_word <= srl_word;
    end
  end
`else
  assign srl_frames    = frame_cnt;
  assign srl_pop       = srl_valid && m_axis_tready;
  assign m_axis_tvalid = srl_valid;
  assign m_word        = srl_word;
  assign count         = srl_count;
`endif

  assign frame_count = frame_cnt;

  always_comb begin
    srl_count_next = srl_count;
    if (in_xfer && !srl_pop) begin
      srl_count_next = srl_count + 1'b1;
    end else if (!in_xfer && srl_pop) begin
      srl_count_next = srl_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srl_count <= '0;
      frame_cnt <= '0;
      pass      <= 1'b0;
      s_ready   <= 1'b0;
    end else begin
      srl_count <= srl_count_next;
      s_ready   <= (srl_count_next != DEPTH_C);
      if ((in_xfer && in_last) && !(out_xfer && m_axis_tlast)) begin
        frame_cnt <= frame_cnt + 1'b1;
      end else if (!(in_xfer && in_last) && (out_xfer && m_axis_tlast)) begin
        frame_cnt <= frame_cnt - 1'b1;
      end
      // A full store with no frame end can never complete: stream it cut-through.
      if (srl_pop && srl_last) begin
        pass <= 1'b0;
      end else if ((srl_count == DEPTH_C) && (srl_frames == '0)) begin
        pass <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_srl_frame_fifo.sv
// tb/tb_axis_srl_frame_fifo.sv - directed bench driving a cut-through and a frame-mode FIFO in parallel.
module tb_axis_srl_frame_fifo;

  localparam int DW = 16;
  localparam int KW = 2;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid;
  logic          s_tlast;
  logic [7:0]    s_tid;
  logic [7:0]    s_tdest;
  logic [0:0]    s_tuser;
  logic          m_tready;

  logic          c_tready, c_tvalid, c_tlast;
  logic [DW-1:0] c_tdata;
  logic [KW-1:0] c_tkeep;
  logic [7:0]    c_tid, c_tdest;
  logic [0:0]    c_tuser;
  logic [CW-1:0] c_count, c_fcount;

  logic          f_tready, f_tvalid, f_tlast;
  logic [DW-1:0] f_tdata;
  logic [KW-1:0] f_tkeep;
  logic [7:0]    f_tid, f_tdest;
  logic [0:0]    f_tuser;
  logic [CW-1:0] f_count, f_fcount;

  axis_srl_frame_fifo #(.DEPTH(16), .DATA_WIDTH(DW), .FRAME_FIFO(0)) u_cut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(c_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(c_tdata), .m_axis_tkeep(c_tkeep), .m_axis_tvalid(c_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(c_tlast), .m_axis_tid(c_tid),
    .m_axis_tdest(c_tdest), .m_axis_tuser(c_tuser),
    .count(c_count), .frame_count(c_fcount)
  );

  axis_srl_frame_fifo #(.DEPTH(16), .DATA_WIDTH(DW), .FRAME_FIFO(1)) u_frm (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(f_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
    .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .m_axis_tdata(f_tdata), .m_axis_tkeep(f_tkeep), .m_axis_tvalid(f_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(f_tlast), .m_axis_tid(f_tid),
    .m_axis_tdest(f_tdest), .m_axis_tuser(f_tuser),
    .count(f_count), .frame_count(f_fcount)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  got;
    int  sent;
    bit  acc;
    bit  seen_full;

    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    s_tid = '0; s_tdest = '0; s_tuser = '0; m_tready = 1'b0;

    // Reset state
    step();
    check("rst_count", c_count, 0);
    check("rst_fcount", c_fcount, 0);
    check("rst_c_tvalid", c_tvalid, 0);
    check("rst_c_tready", c_tready, 0);
    check("rst_f_tvalid", f_tvalid, 0);
    check("rst_f_tready", f_tready, 0);
    rst_n = 1'b1;
    step();
    check("tready_after_rst", c_tready, 1);
    check("f_tready_after_rst", f_tready, 1);

    // Cut-through: each word visible one clock after its transfer
    m_tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(i); s_tkeep = KW'(i); s_tlast = (i == 4);
      s_tuser = 1'(i); s_tid = 8'hA5;
      step();
      check("t1_valid", c_tvalid, 1);
      check("t1_data", c_tdata, i);
      check("t1_count", c_count, 1);
      check("t1_keep", c_tkeep, i & 3);
      check("t1_user", c_tuser, i & 1);
      check("t1_last", c_tlast, (i == 4));
    end
    check("t1_tid_zero", c_tid, 0);
    s_tvalid = 1'b0;
    step();
    check("t1_count_end", c_count, 0);
    check("t1_valid_end", c_tvalid, 0);
    check("t1_fcount_end", c_fcount, 0);

    // Cut-through fill to DEPTH, then drain
    do_reset();
    m_tready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(16'h10 + i);
      step();
    end
    check("t2_full_count", c_count, 16);
    check("t2_full_tready", c_tready, 0);
    s_tdata = 16'h21;
    step();
    check("t2_hold_count", c_count, 16);
    check("t2_hold_data", c_tdata, 16'h11);
    m_tready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 17; cyc++) begin
      acc = s_tvalid && c_tready;
      if (c_tvalid) begin
        check("t2_order", c_tdata, 16'h11 + got);
        got++;
      end
      step();
      if (acc) s_tvalid = 1'b0;
    end
    check("t2_drained", got, 17);
    check("t2_w17_accepted", s_tvalid, 0);
    check("t2_count_end", c_count, 0);

    // Frame mode: 3-word frame withheld until its tlast is stored
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(16'h21 + i); s_tlast = (i == 2);
      step();
      check("t3_gate", f_tvalid, (i == 2));
    end
    check("t3_fcount", f_fcount, 1);
    check("t3_head", f_tdata, 16'h21);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      step();
      check("t3_data", f_tdata, 16'h21 + i);
      check("t3_valid", f_tvalid, 1);
    end
    step();
    check("t3_valid_end", f_tvalid, 0);
    check("t3_fcount_end", f_fcount, 0);
    check("t3_count_end", f_count, 0);

    // Frame mode: oversize frame falls back to cut-through
    do_reset();
    m_tready = 1'b1;
    sent = 0; got = 0; seen_full = 1'b0;
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      s_tvalid = (sent < 20); s_tdata = DW'(16'h31 + sent); s_tlast = (sent == 19);
      if (f_count == 16 && !seen_full) begin
        seen_full = 1'b1;
        check("t4_full_held", f_tvalid, 0);
        check("t4_full_tready", f_tready, 0);
      end
      acc = s_tvalid && f_tready;
      if (f_tvalid) begin
        check("t4_order", f_tdata, 16'h31 + got);
        check("t4_last", f_tlast, (got == 19));
        got++;
      end
      step();
      if (acc) sent++;
    end
    check("t4_delivered", got, 20);
    check("t4_full_seen", seen_full, 1);
    check("t4_fcount_end", f_fcount, 0);
    check("t4_count_end", f_count, 0);
    s_tvalid = 1'b1; s_tdata = 16'h41; s_tlast = 1'b0;
    step();
    s_tvalid = 1'b0;
    step();
    check("t4_pass_cleared", f_tvalid, 0);
    check("t4_partial_count", f_count, 1);
    s_tvalid = 1'b1; s_tdata = 16'h42; s_tlast = 1'b1;
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check("t4_next_valid", f_tvalid, 1);
    check("t4_next_data", f_tdata, 16'h41);
    repeat (2) step();
    check("t4_next_drained", f_count, 0);

    // Frame mode: continuous flow, tlast every 2 words
    do_reset();
    m_tready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      s_tvalid = 1'b1; s_tdata = DW'(16'h50 + k - 1); s_tlast = (((k - 1) % 2) == 1);
      step();
      if (k >= 2) begin
        check("t5_count", f_count, 2);
        check("t5_fcount", f_fcount, 1);
        check("t5_valid", f_tvalid, 1);
        check("t5_tready", f_tready, 1);
        check("t5_data", f_tdata, 16'h50 + k - 2);
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (3) step();
    check("t5_count_end", f_count, 0);

    // Asynchronous reset mid-frame
    do_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1; s_tdata = DW'(16'h60 + i); s_tlast = 1'b0;
      step();
    end
    check("t6_c_count", c_count, 5);
    check("t6_f_count", f_count, 5);
    check("t6_c_valid_pre", c_tvalid, 1);
    s_tvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_c_valid_rst", c_tvalid, 0);
    check("t6_c_tready_rst", c_tready, 0);
    check("t6_c_count_rst", c_count, 0);
    check("t6_f_count_rst", f_count, 0);
    check("t6_f_fcount_rst", f_fcount, 0);
    check("t6_f_tready_rst", f_tready, 0);
    step();
    rst_n = 1'b1;
    step();
    check("t6_tready_back", f_tready, 1);
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 16'h71; s_tlast = 1'b0;
    step();
    s_tdata = 16'h72; s_tlast = 1'b1;
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check("t6_valid", f_tvalid, 1);
    check("t6_data0", f_tdata, 16'h71);
    check("t6_fcount", f_fcount, 1);
    step();
    check("t6_data1", f_tdata, 16'h72);
    step();
    check("t6_count_end", f_count, 0);
    check("t6_fcount_end", f_fcount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
